// File: rtl/branch_resolve_unit_pkg.sv
// Shared opcode numbering and datapath defaults for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int BRU_XLEN_DEFAULT = 32;

  localparam logic [5:0] OP_BEQ    = 6'd32;
  localparam logic [5:0] OP_BGEZ   = 6'd33;
  localparam logic [5:0] OP_BGTZ   = 6'd34;
  localparam logic [5:0] OP_BLEZ   = 6'd35;
  localparam logic [5:0] OP_BLTZ   = 6'd36;
  localparam logic [5:0] OP_BGEZAL = 6'd37;
  localparam logic [5:0] OP_BLTZAL = 6'd38;
  localparam logic [5:0] OP_J      = 6'd39;
  localparam logic [5:0] OP_JAL    = 6'd40;
  localparam logic [5:0] OP_JR     = 6'd41;
  localparam logic [5:0] OP_JALR   = 6'd42;

endpackage

// File: rtl/branch_resolve_unit_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored, and a same-cycle pop+push pops first.
module ras_stack #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            nonempty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr, ptr_dec, ptr_pop;
  logic [PW:0]     cnt, cnt_pop;

  assign nonempty = (cnt != '0);
  assign ptr_dec  = ptr - PW'(1);
  assign top      = mem[ptr_dec];

  always_comb begin
    ptr_pop = ptr;
    cnt_pop = cnt;
    if (pop && nonempty) begin
      ptr_pop = ptr_dec;
      cnt_pop = cnt - (PW+1)'(1);
    end
  end

  // ptr is the next free slot; wraps naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr_pop + PW'(1);
      cnt <= (cnt_pop == FULL) ? cnt_pop : cnt_pop + (PW+1)'(1);
    end else begin
      ptr <= ptr_pop;
      cnt <= cnt_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_pop] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch/jump direction, target, link and misprediction, one registered
// result slot with valid/ready. Define BRANCH_RAS_EN to add the return-address stack.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = BRU_XLEN_DEFAULT,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      inst_num,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic            rs_is_ra,
  input  logic [XLEN-1:0] offset,
  input  logic [25:0]     addr26,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            link_we,
  output logic [XLEN-1:0] link_value,
  output logic            mispredict,
  output logic            illegal,
  output logic            ras_hit
);
  logic            accept;
  logic [XLEN-1:0] seq_pc, br_pc, jmp_pc;
  logic            rs_neg, rs_zero;
  logic            c_cond, c_taken, c_link_we, c_illegal, c_mispredict, c_ras_hit;
  logic [XLEN-1:0] c_target;
  logic            do_push, do_pop;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  assign seq_pc  = pc + XLEN'(4);
  assign br_pc   = pc + (offset << 2);
  assign jmp_pc  = {pc[XLEN-1:28], addr26, 2'b00};
  assign rs_neg  = rs[XLEN-1];
  assign rs_zero = (rs == '0);

  always_comb begin
    c_cond    = 1'b0;
    c_taken   = 1'b0;
    c_target  = seq_pc;
    c_link_we = 1'b0;
    c_illegal = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    case (inst_num)
      OP_BEQ:    begin c_cond = 1'b1; c_taken = (rs == rt); end
      OP_BGEZ:   begin c_cond = 1'b1; c_taken = !rs_neg; end
      OP_BGTZ:   begin c_cond = 1'b1; c_taken = !rs_neg && !rs_zero; end
      OP_BLEZ:   begin c_cond = 1'b1; c_taken = rs_neg || rs_zero; end
      OP_BLTZ:   begin c_cond = 1'b1; c_taken = rs_neg; end
      OP_BGEZAL: begin c_cond = 1'b1; c_taken = !rs_neg; c_link_we = 1'b1; end
      OP_BLTZAL: begin c_cond = 1'b1; c_taken = rs_neg;  c_link_we = 1'b1; end
      OP_J:      begin c_taken = 1'b1; c_target = jmp_pc; end
      OP_JAL:    begin c_taken = 1'b1; c_target = jmp_pc; c_link_we = 1'b1; do_push = 1'b1; end
      OP_JR:     begin c_taken = 1'b1; c_target = rs; do_pop = rs_is_ra; end
      OP_JALR:   begin
        c_taken   = 1'b1;
        c_target  = rs;
        c_link_we = 1'b1;
        do_pop    = rs_is_ra;
        do_push   = 1'b1;
      end
      default:   c_illegal = 1'b1;
    endcase
    if (c_cond && c_taken) c_target = br_pc;
  end

  assign c_mispredict = (c_taken != pred_taken) || (c_taken && (c_target != pred_target));

`ifdef BRANCH_RAS_EN
  logic [XLEN-1:0] ras_top;
  logic            ras_nonempty;

  ras_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && do_push),
    .pop       (accept && do_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .nonempty  (ras_nonempty)
  );

  // hit is judged against the stack state before this request's own update
  assign c_ras_hit = (inst_num == OP_JR) && do_pop && ras_nonempty && (ras_top == rs);
`else
  logic unused_ras;
  assign unused_ras = do_push ^ do_pop ^ (RAS_DEPTH > 1);
  assign c_ras_hit  = 1'b0;
`endif

  // result fields load only on accept, so they hold while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      taken      <= 1'b0;
      target     <= '0;
      link_we    <= 1'b0;
      link_value <= '0;
      mispredict <= 1'b0;
      illegal    <= 1'b0;
      ras_hit    <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      taken      <= c_taken;
      target     <= c_target;
      link_we    <= c_link_we;
      link_value <= seq_pc;
      mispredict <= c_mispredict;
      illegal    <= c_illegal;
      ras_hit    <= c_ras_hit;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; RAS scenarios run when
// BRANCH_RAS_EN is defined, otherwise ras_hit is checked to stay 0.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [5:0]  inst_num;
  logic [31:0] pc, rs, rt, offset, pred_target;
  logic        rs_is_ra, pred_taken, flush;
  logic [25:0] addr26;
  logic        out_valid, out_ready;
  logic        taken, link_we, mispredict, illegal, ras_hit;
  logic [31:0] target, link_value;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolve_unit #(.XLEN(32), .RAS_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inst_num(inst_num), .pc(pc), .rs(rs), .rt(rt), .rs_is_ra(rs_is_ra),
    .offset(offset), .addr26(addr26), .pred_taken(pred_taken),
    .pred_target(pred_target), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .target(target), .link_we(link_we),
    .link_value(link_value), .mispredict(mispredict), .illegal(illegal),
    .ras_hit(ras_hit)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [5:0] op, input logic [31:0] p, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] off, input logic pt,
                     input logic [31:0] ptg, input logic ra);
    inst_num = op; pc = p; rs = a; rt = b; offset = off;
    pred_taken = pt; pred_target = ptg; rs_is_ra = ra; in_valid = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; addr26 = 26'h40;
    req(OP_BEQ, 32'h10, 32'h1, 32'h1, 32'h1, 1'b0, 32'h0, 1'b0);
    cyc; cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (target !== 32'h0) begin n_err++; $display("FAIL reset_target got %h want 0", target); end
    n_cmp++; if (ras_hit !== 1'b0) begin n_err++; $display("FAIL reset_ras_hit got %b want 0", ras_hit); end
    in_valid = 1'b0;
    reset = 1'b0;
    cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got %b want 0", out_valid); end
  endtask

  task automatic test_beq;
    req(OP_BEQ, 32'h100, 32'h5, 32'h5, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    cyc; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid got %b want 1", out_valid); end
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL beq_taken got %b want 1", taken); end
    n_cmp++; if (target !== 32'hFC) begin n_err++; $display("FAIL beq_target got %h want fc", target); end
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL beq_mispredict got %b want 1", mispredict); end
    n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL beq_link_we got %b want 0", link_we); end
    cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL beq_drain got %b want 0", out_valid); end
  endtask

  task automatic test_bltzal;
    req(OP_BLTZAL, 32'h200, 32'h8000_0000, 32'h0, 32'h4, 1'b1, 32'h210, 1'b0);
    cyc; in_valid = 1'b0;
    n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL bltzal_taken got %b want 1", taken); end
    n_cmp++; if (target !== 32'h210) begin n_err++; $display("FAIL bltzal_target got %h want 210", target); end
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL bltzal_mispredict got %b want 0", mispredict); end
    n_cmp++; if (link_we !== 1'b1) begin n_err++; $display("FAIL bltzal_link_we got %b want 1", link_we); end
    n_cmp++; if (link_value !== 32'h204) begin n_err++; $display("FAIL bltzal_link_value got %h want 204", link_value); end
    cyc;
  endtask

  typedef struct {
    logic [5:0] op; logic [31:0] a; logic [31:0] b;
    logic tk; logic [31:0] tg; logic lw;
  } vec_t;

  // pc=0x1000, offset=8 (taken cond -> 0x1020), addr26=0x40 (jump -> 0x100), pred_taken=0
  task automatic test_opcodes;
    vec_t tbl [13];
    tbl[0]  = '{OP_BEQ,    32'h3,         32'h4, 1'b0, 32'h1004, 1'b0};
    tbl[1]  = '{OP_BGEZ,   32'h0,         32'h0, 1'b1, 32'h1020, 1'b0};
    tbl[2]  = '{OP_BGEZ,   32'hFFFF_FFFF, 32'h0, 1'b0, 32'h1004, 1'b0};
    tbl[3]  = '{OP_BGTZ,   32'h0,         32'h0, 1'b0, 32'h1004, 1'b0};
    tbl[4]  = '{OP_BGTZ,   32'h1,         32'h0, 1'b1, 32'h1020, 1'b0};
    tbl[5]  = '{OP_BLEZ,   32'h0,         32'h0, 1'b1, 32'h1020, 1'b0};
    tbl[6]  = '{OP_BLEZ,   32'h7FFF_FFFF, 32'h0, 1'b0, 32'h1004, 1'b0};
    tbl[7]  = '{OP_BLTZ,   32'h1,         32'h0, 1'b0, 32'h1004, 1'b0};
    tbl[8]  = '{OP_BGEZAL, 32'h5,         32'h0, 1'b1, 32'h1020, 1'b1};
    tbl[9]  = '{OP_JR,     32'h2468,      32'h0, 1'b1, 32'h2468, 1'b0};
    tbl[10] = '{OP_JALR,   32'h3000,      32'h0, 1'b1, 32'h3000, 1'b1};
    tbl[11] = '{OP_J,      32'h0,         32'h0, 1'b1, 32'h0100, 1'b0};
    tbl[12] = '{OP_JAL,    32'h0,         32'h0, 1'b1, 32'h0100, 1'b1};
    addr26 = 26'h40;
    for (int i = 0; i < 13; i++) begin
      req(tbl[i].op, 32'h1000, tbl[i].a, tbl[i].b, 32'h8, 1'b0, 32'h0, 1'b0);
      cyc; in_valid = 1'b0;
      n_cmp++; if (taken !== tbl[i].tk) begin n_err++; $display("FAIL op%0d_taken got %b want %b", i, taken, tbl[i].tk); end
      n_cmp++; if (target !== tbl[i].tg) begin n_err++; $display("FAIL op%0d_target got %h want %h", i, target, tbl[i].tg); end
      n_cmp++; if (link_we !== tbl[i].lw) begin n_err++; $display("FAIL op%0d_link_we got %b want %b", i, link_we, tbl[i].lw); end
      n_cmp++; if (link_value !== 32'h1004) begin n_err++; $display("FAIL op%0d_link_value got %h want 1004", i, link_value); end
      n_cmp++; if (mispredict !== tbl[i].tk) begin n_err++; $display("FAIL op%0d_mispredict got %b want %b", i, mispredict, tbl[i].tk); end
      n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL op%0d_illegal got %b want 0", i, illegal); end
    end
    addr26 = 26'h40;
    req(OP_J, 32'hF000_0100, 32'h0, 32'h0, 32'h0, 1'b1, 32'hF000_0100, 1'b0);
    cyc; in_valid = 1'b0;
    n_cmp++; if (target !== 32'hF000_0100) begin n_err++; $display("FAIL j_region_target got %h want f0000100", target); end
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL j_region_mispredict got %b want 0", mispredict); end
    cyc;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    req(OP_BGEZ, 32'h600, 32'h1, 32'h0, 32'h10, 1'b1, 32'h640, 1'b0);
    cyc;
    req(OP_BLTZ, 32'h700, 32'h1, 32'h0, 32'h10, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d got %b want 1", i, out_valid); end
      n_cmp++; if (target !== 32'h640) begin n_err++; $display("FAIL bp_hold_target%0d got %h want 640", i, target); end
      n_cmp++; if (taken !== 1'b1) begin n_err++; $display("FAIL bp_hold_taken%0d got %b want 1", i, taken); end
      if (i < 2) cyc;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    cyc; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_valid got %b want 1", out_valid); end
    n_cmp++; if (target !== 32'h704) begin n_err++; $display("FAIL bp_second_target got %h want 704", target); end
    n_cmp++; if (taken !== 1'b0) begin n_err++; $display("FAIL bp_second_taken got %b want 0", taken); end
    cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_flush;
    out_ready = 1'b0;
    req(OP_BEQ, 32'h500, 32'h9, 32'h9, 32'h1, 1'b1, 32'h0, 1'b0);
    cyc; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %b want 0", out_valid); end
    n_cmp++; if (taken !== 1'b0) begin n_err++; $display("FAIL rst_async_taken got %b want 0", taken); end
    n_cmp++; if (target !== 32'h0) begin n_err++; $display("FAIL rst_async_target got %h want 0", target); end
    n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL rst_async_mispredict got %b want 0", mispredict); end
    n_cmp++; if (link_value !== 32'h0) begin n_err++; $display("FAIL rst_async_link_value got %h want 0", link_value); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    cyc; reset = 1'b0; out_ready = 1'b1;
    req(OP_BLTZAL, 32'h800, 32'h8000_0000, 32'h0, 32'h4, 1'b0, 32'h0, 1'b0);
    flush = 1'b1;
    cyc; flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_accept_valid got %b want 0", out_valid); end
    cyc;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped_valid got %b want 0", out_valid); end
    out_ready = 1'b0;
    req(OP_J, 32'h900, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc; in_valid = 1'b0; flush = 1'b1;
    cyc; flush = 1'b0; out_ready = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_held_valid got %b want 0", out_valid); end
    req(6'd7, 32'h300, 32'h0, 32'h0, 32'h0, 1'b1, 32'h304, 1'b0);
    cyc; in_valid = 1'b0;
    n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got %b want 1", illegal); end
    n_cmp++; if (taken !== 1'b0) begin n_err++; $display("FAIL ill_taken got %b want 0", taken); end
    n_cmp++; if (target !== 32'h304) begin n_err++; $display("FAIL ill_target got %h want 304", target); end
    n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL ill_link_we got %b want 0", link_we); end
    n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL ill_mispredict got %b want 1", mispredict); end
    cyc;
  endtask

  task automatic pulse_reset;
    reset = 1'b1; cyc; reset = 1'b0;
  endtask

`ifdef BRANCH_RAS_EN
  task automatic test_ras;
    pulse_reset;
    addr26 = 26'h40;
    req(OP_JAL, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0);
    cyc;
    req(OP_JR, 32'h800, 32'h404, 32'h0, 32'h0, 1'b1, 32'h404, 1'b1);
    cyc;
    n_cmp++; if (ras_hit !== 1'b1) begin n_err++; $display("FAIL ras_pop_hit got %b want 1", ras_hit); end
    n_cmp++; if (target !== 32'h404) begin n_err++; $display("FAIL ras_pop_target got %h want 404", target); end
    req(OP_JR, 32'h800, 32'h404, 32'h0, 32'h0, 1'b1, 32'h404, 1'b1);
    cyc; in_valid = 1'b0;
    n_cmp++; if (ras_hit !== 1'b0) begin n_err++; $display("FAIL ras_empty_hit got %b want 0", ras_hit); end
    cyc;
  endtask

  task automatic test_ras_overflow;
    pulse_reset;
    for (int i = 0; i < 9; i++) begin
      req(OP_JAL, 32'h1000 + 32'h10 * i, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      cyc;
    end
    for (int i = 8; i >= 1; i--) begin
      req(OP_JR, 32'h0, 32'h1004 + 32'h10 * i, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
      cyc;
      n_cmp++; if (ras_hit !== 1'b1) begin n_err++; $display("FAIL ras_ovf_pop%0d got %b want 1", i, ras_hit); end
    end
    req(OP_JR, 32'h0, 32'h1004, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    cyc; in_valid = 1'b0;
    n_cmp++; if (ras_hit !== 1'b0) begin n_err++; $display("FAIL ras_ovf_oldest got %b want 0", ras_hit); end
    cyc;
  endtask
`else
  task automatic test_no_ras;
    pulse_reset;
    addr26 = 26'h40;
    req(OP_JAL, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0);
    cyc;
    req(OP_JR, 32'h800, 32'h404, 32'h0, 32'h0, 1'b1, 32'h404, 1'b1);
    cyc; in_valid = 1'b0;
    n_cmp++; if (ras_hit !== 1'b0) begin n_err++; $display("FAIL no_ras_hit got %b want 0", ras_hit); end
    n_cmp++; if (target !== 32'h404) begin n_err++; $display("FAIL no_ras_target got %h want 404", target); end
    cyc;
  endtask
`endif

  initial begin
    test_reset;
    test_beq;
    test_bltzal;
    test_opcodes;
    test_back_to_back;
    test_reset_flush;
`ifdef BRANCH_RAS_EN
    test_ras;
    test_ras_overflow;
`else
    test_no_ras;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width (legal values 32 or 64).
REQ-002 The block SHALL have parameter RAS_DEPTH, default 8, giving the return-address-stack entry count (power of two, 2..32).
REQ-003 The ports SHALL be, clock and reset first:
clk  in  1  clock.
reset  in  1  asynchronous, active-high.
in_valid  in  1  request valid.
in_ready  out  1  request accepted when in_valid is also high.
inst_num  in  6  opcode: 32 BEQ, 33 BGEZ, 34 BGTZ, 35 BLEZ, 36 BLTZ, 37 BGEZAL, 38 BLTZAL, 39 J, 40 JAL, 41 JR, 42 JALR.
pc  in  XLEN  instruction address.
rs, rt  in  XLEN  operands.
rs_is_ra  in  1  rs field equals register 31.
offset  in  XLEN  sign-extended 16-bit immediate.
addr26  in  26  jump field.
pred_taken  in  1  front-end prediction of the direction.
pred_target  in  XLEN  front-end prediction of the target.
flush  in  1  discards the held result.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
taken, target  out  1/XLEN  resolved direction and next pc.
link_we, link_value  out  1/XLEN  link write enable and link value.
mispredict  out  1  prediction wrong.
illegal  out  1  inst_num outside 32..42.
ras_hit  out  1  return-address-stack prediction matched the actual target.

Function
REQ-004 The block SHALL accept a request on the clk edge where in_valid and in_ready are both high.
REQ-005 in_ready SHALL equal !out_valid || out_ready.
REQ-006 The result SHALL be registered with 1-cycle latency: out_valid rises on the edge after acceptance.
REQ-007 All outputs SHALL hold stable while out_valid && !out_ready.
REQ-008 The branch conditions SHALL be, with signed comparison against zero:
- BEQ: rs==rt.
- BGEZ, BGEZAL: rs>=0.
- BGTZ: rs>0.
- BLEZ: rs<=0.
- BLTZ, BLTZAL: rs<0.
- J, JAL, JR, JALR: always taken.
REQ-009 target SHALL be:
- conditional taken: pc + (offset<<2), computed modulo 2^XLEN.
- conditional not taken: pc+4.
- J/JAL: {pc[XLEN-1:28], addr26, 2'b00}.
- JR/JALR: rs.
REQ-010 link_value SHALL be pc+4 for every opcode; link_we SHALL be 1 only for 37, 38, 40 and 42.
REQ-011 mispredict SHALL be (taken != pred_taken) || (taken && target != pred_target).
REQ-012 For an illegal opcode the block SHALL output illegal=1, taken=0, target=pc+4, link_we=0, mispredict=pred_taken.
REQ-013 flush SHALL clear out_valid on the next edge and block acceptance that cycle; when flush and acceptance coincide, flush wins and the request is dropped.

Reset
REQ-014 Asserting reset SHALL immediately set out_valid, taken, link_we, mispredict, illegal and ras_hit to 0, target and link_value to 0, and the RAS pointer and count to 0, regardless of any transfer in progress.
REQ-015 in_ready SHALL read 1 while reset is held and SHALL still accept nothing until the first edge after reset deasserts.

Configuration
REQ-016 With BRANCH_RAS_EN defined, the block SHALL contain a RAS_DEPTH-entry return-address stack of XLEN-bit entries, updated only on accepted, non-flushed requests.
REQ-017 On JAL or JALR the RAS SHALL push pc+4; when full it wraps and overwrites the oldest entry, with count saturating at RAS_DEPTH.
REQ-018 On JR with rs_is_ra=1 the RAS SHALL pop, and ras_hit SHALL be (count>0 && top==rs).
REQ-019 A pop on an empty RAS SHALL leave the RAS unchanged and give ras_hit=0.
REQ-020 JALR with rs_is_ra=1 SHALL pop before it pushes.
REQ-021 Without BRANCH_RAS_EN, ras_hit SHALL be tied to 0 and the block SHALL contain no stack storage.

Structure
REQ-022 The shared package SHALL hold the inst_num constants (32..42) and the default XLEN.
REQ-023 The return-address stack SHALL be a sub-module, ras_stack, instantiated only under BRANCH_RAS_EN.

Verification
REQ-024 The bench SHALL cover at least these directed scenarios:
- BEQ, pc=0x100, rs=rt=5, offset=0xFFFFFFFF, pred_taken=0 -> taken=1, target=0xFC, mispredict=1, link_we=0.
- BLTZAL, rs=0x80000000, pc=0x200, offset=4, pred_taken=1, pred_target=0x210 -> taken=1, target=0x210, mispredict=0, link_we=1, link_value=0x204.
- Backpressure: two requests back-to-back with out_ready=0 for 3 cycles -> in_ready=0, first result held stable, second accepted in the cycle out_ready rises.
- RAS: JAL at pc=0x400, then JR with rs_is_ra=1 and rs=0x404 -> ras_hit=1; a second JR with rs_is_ra=1 -> ras_hit=0 (empty).
- RAS overflow: 9 pushes with RAS_DEPTH=8, then 8 pops -> ras_hit=1 on all 8 pops, and the overwritten oldest entry is never returned.
- Reset asserted while out_valid=1 and a flush coincides with acceptance -> outputs 0 immediately; the flushed request never appears at the output; inst_num=7 -> illegal=1, target=pc+4.
